decode_hazard_ctrl: RTL
=======================

Name: decode_hazard_ctrl

Overview:
- Hazard scheduler for the decode stage of the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes the decoded fields of the instruction in ID (opcode, rd, rs1, rs2) and keeps a 3-deep scoreboard of in-flight writers (EX, MEM, WB).
- Generates the IF/ID stall, bubble insertion into ID/EX, and registered forwarding selects aligned to the instruction in EX.
- Sits beside the instruction decoder; drives PC/IF-ID enables and the EX operand muxes.

Parameters:
- REG_BITS, 5, register index width.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_OPCODE  in  7  opcode of the ID instruction.
- ID_RD  in  REG_BITS  destination register.
- ID_RS1  in  REG_BITS  source 1.
- ID_RS2  in  REG_BITS  source 2.
- FLUSH  in  1  taken branch/jump resolved in EX this cycle.
- HOLD  in  1  whole-pipe freeze (data memory wait).
- STALL  out  1  combinational; hold PC and IF/ID this cycle.
- EX_VALID  out  1  registered; EX holds a real instruction.
- EX_FWD_A  out  2  registered; operand A select for EX: 00 RF, 01 EX/MEM result, 10 MEM/WB result.
- EX_FWD_B  out  2  registered; same encoding for operand B.
- STALL_COUNT  out  STALL_CNT_W  cycles with STALL=1 caused by hazard (not HOLD), saturating.

Behaviour:
- Opcode classes:
  - uses_rs1: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
  - uses_rs2: OP 0110011, STORE 0100011, BRANCH 1100011.
  - writes: OP, OP-IMM 0010011, LOAD 0000011, LUI, AUIPC, JAL, JALR 1100111, and only when rd != 0.
  - is_load: LOAD.
  - Unknown opcodes: no use, no write.
- Scoreboard records EXr, MEMr, WBr each hold {valid, writes, is_load, rd}.
- A "match on rsN" means: record valid & writes & rd == rsN & usesN & rsN != 0.
- Load-use: hz = ID_VALID & (EXr.is_load matches rs1 or rs2).
- STALL = HOLD | (hz & ~FLUSH). FLUSH overrides the hazard stall but never overrides HOLD.
- Each edge when HOLD=0:
  - WBr <= MEMr; MEMr <= EXr.
  - EXr <= ID record if ID_VALID & ~hz & ~FLUSH, else a bubble (valid=0).
  - EX_VALID follows EXr.valid.
- Forward select, computed in ID, registered with EXr; priority is youngest first:
  - EXr match -> 01 (producer will be in MEM).
  - else MEMr match -> 10.
  - else 00. A WBr match needs no forward because the RF is write-through.
  - A bubble or flushed entry registers 00/00.
- HOLD=1: all records, EX_VALID, EX_FWD_* and STALL_COUNT hold; STALL=1.
- STALL_COUNT increments when HOLD=0 & hz & ~FLUSH, and saturates at all ones.
- Reset: all records invalid; EX_VALID=0, EX_FWD_A=EX_FWD_B=00, STALL_COUNT=0. STALL=0 after reset unless HOLD=1.
  - RST mid-stall clears the scoreboard; the next cycle the ID instruction advances.
- Latency: a load-use stall lasts exactly 1 cycle. An ALU-to-ALU dependence costs 0 cycles.

Optional Feature:
- Macro: HAZ_FORWARD_EN.
- Defined: behaviour as above.
- Undefined:
  - No forwarding; EX_FWD_A/B tied to 00.
  - hz = ID_VALID & (EXr or MEMr matches rs1 or rs2), for any writer, not only loads.
  - A dependent ALU op stalls 2 cycles; a load-use stalls 2 cycles.
  - STALL_COUNT counts every such cycle.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3 back-to-back -> STALL stays 0; second instruction in EX with EX_FWD_A=01, EX_FWD_B=00. Without HAZ_FORWARD_EN: 2 stall cycles, then FWD=00.
- lw x7,0(x1) then add x8,x7,x7 -> STALL=1 for exactly 1 cycle, a bubble enters EX (EX_VALID=0), then the add enters with EX_FWD_A=EX_FWD_B=10; STALL_COUNT=1.
- Producer writes x0 (addi x0,x0,1), consumer reads x0 -> no stall, FWD=00.
- lw x7 then dependent add, with FLUSH=1 in the hazard cycle -> STALL=0, next EX_VALID=0, STALL_COUNT unchanged.
- HOLD=1 for 3 cycles mid load-use -> STALL=1, all outputs frozen, STALL_COUNT unchanged. After release: one hazard stall cycle, then forwarding 10.
- RST asserted during a load-use stall -> next cycle EX_VALID=0, FWD=00, STALL_COUNT=0, STALL=0. Preload STALL_COUNT near saturation, force further hazards -> counter holds at 0xFFFF.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage hazard scheduler with an EX/MEM/WB in-flight writer scoreboard.
// Build macro HAZ_FORWARD_EN: forwarding selects plus load-use-only stalls; undefined: stall on any RAW to EX/MEM.
module decode_hazard_ctrl #(
  parameter int REG_BITS    = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ID_VALID,
  input  logic [6:0]             ID_OPCODE,
  input  logic [REG_BITS-1:0]    ID_RD,
  input  logic [REG_BITS-1:0]    ID_RS1,
  input  logic [REG_BITS-1:0]    ID_RS2,
  input  logic                   FLUSH,
  input  logic                   HOLD,
  output logic                   STALL,
  output logic                   EX_VALID,
  output logic [1:0]             EX_FWD_A,
  output logic [1:0]             EX_FWD_B,
  output logic [STALL_CNT_W-1:0] STALL_COUNT
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic                valid;
    logic                writes;
    logic                is_load;
    logic [REG_BITS-1:0] rd;
  } rec_t;

  rec_t ex_r, mem_r, wb_r, id_rec;
  logic uses1, uses2, writes, is_load;
  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic hz, advance;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic sb_unused;

  function automatic logic rec_match(input rec_t r, input logic [REG_BITS-1:0] rs, input logic uses);
    return r.valid & r.writes & (r.rd == rs) & uses & (rs != '0);
  endfunction

  always_comb begin
    uses1   = 1'b0;
    uses2   = 1'b0;
    writes  = 1'b0;
    is_load = 1'b0;
    case (ID_OPCODE)
      OPC_OP:     begin uses1 = 1'b1; uses2 = 1'b1; writes = 1'b1; end
      OPC_OPIMM:  begin uses1 = 1'b1; writes = 1'b1; end
      OPC_LOAD:   begin uses1 = 1'b1; writes = 1'b1; is_load = 1'b1; end
      OPC_STORE:  begin uses1 = 1'b1; uses2 = 1'b1; end
      OPC_BRANCH: begin uses1 = 1'b1; uses2 = 1'b1; end
      OPC_JALR:   begin uses1 = 1'b1; writes = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    id_rec.valid   = 1'b1;
    id_rec.writes  = writes & (ID_RD != '0);
    id_rec.is_load = is_load;
    id_rec.rd      = ID_RD;
  end

  assign ex_m1  = rec_match(ex_r,  ID_RS1, uses1);
  assign ex_m2  = rec_match(ex_r,  ID_RS2, uses2);
  assign mem_m1 = rec_match(mem_r, ID_RS1, uses1);
  assign mem_m2 = rec_match(mem_r, ID_RS2, uses2);

`ifdef HAZ_FORWARD_EN
  assign hz = ID_VALID & ex_r.is_load & (ex_m1 | ex_m2);
`else
  assign hz = ID_VALID & (ex_m1 | ex_m2 | mem_m1 | mem_m2);
`endif

  assign advance     = ID_VALID & ~hz & ~FLUSH;
  assign STALL       = HOLD | (hz & ~FLUSH);
  assign EX_VALID    = ex_r.valid;
  assign STALL_COUNT = stall_cnt;

  // WB is tracked for completeness; the RF is write-through so nothing reads it.
  assign sb_unused = ^{wb_r, mem_r.is_load, ex_r.is_load};

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_r      <= '0;
      mem_r     <= '0;
      wb_r      <= '0;
      stall_cnt <= '0;
    end else if (!HOLD) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= advance ? id_rec : '0;
      if (hz && !FLUSH && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

`ifdef HAZ_FORWARD_EN
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

  // Youngest producer wins: EX copy is newer than the MEM copy.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (ex_m1)       fwd_a_d = 2'b01;
    else if (mem_m1) fwd_a_d = 2'b10;
    if (ex_m2)       fwd_b_d = 2'b01;
    else if (mem_m2) fwd_b_d = 2'b10;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (!HOLD) begin
      fwd_a_q <= advance ? fwd_a_d : 2'b00;
      fwd_b_q <= advance ? fwd_b_d : 2'b00;
    end
  end

  assign EX_FWD_A = fwd_a_q;
  assign EX_FWD_B = fwd_b_q;
`else
  assign EX_FWD_A = 2'b00;
  assign EX_FWD_B = 2'b00;
`endif

endmodule
